// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared encodings for the memory arbiter.
//
// Holds the memory access size codes understood by memctrl, the owner
// encoding that records who is waiting for read data, and the lock-state
// encoding used when locked (SWP) sequencing is compiled in with the
// MEM_ARB_LOCK_EN macro.
package mem_arb_pkg;

    // Access size codes, shared with memctrl.
    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;

    // Owner of the transfer whose read data returns next cycle.
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_DM   = 2'd2;

    // Lock sequencing states.
    localparam logic LOCK_IDLE   = 1'b0;
    localparam logic LOCK_LOCKED = 1'b1;

    // One memctrl request as seen on the memctrl side.
    typedef struct packed {
        logic        wr;
        logic        sign;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_starve.sv
// mem_arb_starve -- instruction-fetch starvation counter.
//
// Counts consecutive enabled cycles in which fetch requests but is not
// granted, saturating at STARVE_MAX. The count clears on an enabled cycle
// with a fetch grant or with no fetch request. 'starved' tells the arbiter
// that fetch must win this cycle.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           pipeline enable; the counter holds while en=0
//   if_vld       fetch request this cycle
//   if_gnt       fetch grant this cycle
//   starved      count has reached STARVE_MAX
module mem_arb_starve #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic if_vld,
    input  logic if_gnt,
    output logic starved
);

    localparam logic [3:0] MAX_CNT = 4'(STARVE_MAX);

    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (if_vld && !if_gnt) begin
            if (cnt_reg != MAX_CNT) begin
                cnt_next = cnt_reg + 4'd1;
            end
        end else begin
            cnt_next = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= 4'd0;
        end else if (en) begin
            cnt_reg <= cnt_next;
        end
    end

    assign starved = (cnt_reg == MAX_CNT);

endmodule

// File: rtl/mem_arb.sv
// mem_arb -- arbiter between instruction fetch and data memory for memctrl.
//
// Data has fixed priority over fetch, except that fetch is forced to win
// once it has been denied for STARVE_MAX consecutive enabled cycles. The
// grant is combinational; the winner's request is steered onto the
// memctrl-side ports. Read data comes back one enabled cycle later and is
// routed to whichever requester owned the read.
//
// Optional feature: define MEM_ARB_LOCK_EN to compile in locked (SWP)
// sequencing. A data grant with i_dm_lock=1 enters LOCKED, a data grant with
// i_dm_lock=0 returns to IDLE, and fetch is denied entirely while LOCKED.
// Without the macro i_dm_lock is ignored.
//
// Ports:
//   clk, rst_n, en      clock, async active-low reset, pipeline enable
//   i_if_*, o_if_*      fetch request, grant, read response
//   i_dm_*, o_dm_*      data request, grant, read response
//   o_memctrl_*         request towards memctrl
//   i_memctrl_rdata     read data from memctrl
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    // fetch
    input  logic        i_if_vld,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvld,
    output logic [31:0] o_if_rdata,
    // data
    input  logic        i_dm_vld,
    input  logic        i_dm_wr,
    input  logic        i_dm_sign,
    input  logic [1:0]  i_dm_size,
    input  logic        i_dm_lock,
    input  logic [31:0] i_dm_addr,
    input  logic [31:0] i_dm_wdata,
    output logic        o_dm_gnt,
    output logic        o_dm_rvld,
    output logic [31:0] o_dm_rdata,
    // memctrl side
    output logic        o_memctrl_vld,
    output logic        o_memctrl_wr,
    output logic        o_memctrl_sign,
    output logic [1:0]  o_memctrl_size,
    output logic [31:0] o_memctrl_addr,
    output logic [31:0] o_memctrl_wdata,
    input  logic [31:0] i_memctrl_rdata
);

    logic       starved;
    logic       fetch_blocked;
    logic       if_win;
    logic [1:0] owner_reg;
    logic [1:0] owner_next;

`ifdef MEM_ARB_LOCK_EN
    logic lock_state_reg;
    logic lock_state_next;

    always_comb begin
        lock_state_next = lock_state_reg;
        if (o_dm_gnt) begin
            lock_state_next = i_dm_lock ? LOCK_LOCKED : LOCK_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_state_reg <= LOCK_IDLE;
        end else if (en) begin
            lock_state_reg <= lock_state_next;
        end
    end

    // Locked sequencing beats starvation: fetch stays out until unlock.
    assign fetch_blocked = (lock_state_reg == LOCK_LOCKED);
`else
    logic unused_lock;
    assign unused_lock   = i_dm_lock;
    assign fetch_blocked = 1'b0;
`endif

    // Fetch wins when forced by starvation or when data is not asking.
    assign if_win   = en & i_if_vld & ~fetch_blocked & (starved | ~i_dm_vld);
    assign o_if_gnt = if_win;
    assign o_dm_gnt = en & i_dm_vld & ~if_win;

    mem_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .if_vld  (i_if_vld),
        .if_gnt  (o_if_gnt),
        .starved (starved)
    );

    // Request steering onto memctrl.
    always_comb begin
        o_memctrl_vld   = o_if_gnt | o_dm_gnt;
        o_memctrl_wr    = 1'b0;
        o_memctrl_sign  = 1'b0;
        o_memctrl_size  = MEM_W;
        o_memctrl_addr  = 32'd0;
        o_memctrl_wdata = 32'd0;
        if (o_if_gnt) begin
            o_memctrl_addr = i_if_addr;
        end else if (o_dm_gnt) begin
            o_memctrl_wr    = i_dm_wr;
            o_memctrl_sign  = i_dm_sign;
            o_memctrl_size  = i_dm_size;
            o_memctrl_addr  = i_dm_addr;
            o_memctrl_wdata = i_dm_wdata;
        end
    end

    // Owner of next cycle's read data; writes produce no response.
    always_comb begin
        owner_next = owner_reg;
        if (en) begin
            if (o_if_gnt) begin
                owner_next = OWN_IF;
            end else if (o_dm_gnt && !i_dm_wr) begin
                owner_next = OWN_DM;
            end else begin
                owner_next = OWN_NONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg <= OWN_NONE;
        end else begin
            owner_reg <= owner_next;
        end
    end

    assign o_if_rvld  = (owner_reg == OWN_IF);
    assign o_dm_rvld  = (owner_reg == OWN_DM);
    assign o_if_rdata = o_if_rvld ? i_memctrl_rdata : 32'd0;
    assign o_dm_rdata = o_dm_rvld ? i_memctrl_rdata : 32'd0;

endmodule
